// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/sub_bit_cell.sv
// One-bit combinational full subtractor: d = a - b - c, bo = borrow out.
module sub_bit_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic d_o,
  output logic bo_o
);

  assign d_o  = a_i ^ b_i ^ c_i;
  assign bo_o = (~a_i & b_i) | (~a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (A - B - Bin), LSB first, start/busy/done handshake.
// Optional signed overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               borrow_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-2:0]   res_q;
  logic [WIDTH-2:0]   res_d;
  logic [WIDTH-1:0]   diff_q;
  logic               bout_q;
  logic               busy_q;
  logic               done_q;
  logic               cell_d;
  logic               cell_bo;
`ifdef SERIAL_SUB_OVF_EN
  logic               ovf_q;
`endif

  sub_bit_cell u_cell (
    .a_i  (a_q[0]),
    .b_i  (b_q[0]),
    .c_i  (borrow_q),
    .d_o  (cell_d),
    .bo_o (cell_bo)
  );

  // Partial result keeps only the WIDTH-1 earlier bits; the final bit comes straight from the cell.
  assign res_d = (WIDTH-1)'({cell_d, res_q} >> 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q      <= a_in;
            b_q      <= b_in;
            borrow_q <= bin;
            cnt_q    <= '0;
            res_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= SHIFT;
          end else begin
            state_q  <= IDLE;
          end
        end
        SHIFT: begin
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          borrow_q <= cell_bo;
          res_q    <= res_d;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            diff_q  <= {cell_d, res_q};
            bout_q  <= cell_bo;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
`ifdef SERIAL_SUB_OVF_EN
            // Operand sign bits are in bit 0 now and cell_d is the result sign.
            ovf_q   <= (a_q[0] != b_q[0]) && (cell_d != a_q[0]);
`endif
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor that computes A − B − Bin, one bit per clock, LSB first.
- Wraps a one-bit full-subtractor cell and feeds its borrow output back through a registered borrow flop.
- Sits downstream of the combinational full-subtractor stage. Consumes its difference/borrow per cycle and assembles a parallel WIDTH-bit result with a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active low; sampled on rising clk edge.
- start  input  1  request; sampled only in IDLE or DONE.
- a_in  input  WIDTH  minuend, captured on accepted start.
- b_in  input  WIDTH  subtrahend, captured on accepted start.
- bin  input  1  initial borrow-in, captured on accepted start.
- busy  output  1  high while bits are being processed (SHIFT state).
- done  output  1  one-cycle pulse when the result is valid.
- diff  output  WIDTH  result A − B − Bin modulo 2^WIDTH; held until the next accepted start.
- bout  output  1  final borrow out (1 = A < B + Bin, unsigned).

Behaviour:
- Reset (rst_n=0 at clock edge): state=IDLE; busy=0, done=0, diff=0, bout=0; shift registers, borrow flop and bit counter cleared. Reset overrides all other inputs, including mid-operation; any partial result is discarded.
- States: IDLE, SHIFT, DONE.
  - IDLE: start=1 → capture a_in, b_in into shift regs, bin into borrow flop, count=0, go to SHIFT. Otherwise stay.
  - SHIFT: each cycle the cell takes a=A[0], b=B[0], c=borrow.
    - Diff bit is shifted into the result MSB (right-shift), so after WIDTH cycles bit 0 is in the LSB.
    - Borrow flop gets the cell borrow; A and B shift right; count increments.
    - When count==WIDTH−1 in this cycle: load diff and bout from the final values and go to DONE.
  - DONE: done=1 for exactly this cycle. start=1 here is accepted exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
- Latency: start accepted at edge k; busy high for cycles k+1..k+WIDTH; done high in the cycle after edge k+WIDTH. Total WIDTH+1 cycles from start to done.
- start during SHIFT is ignored. Operands are not re-sampled.
- diff and bout change only on the DONE transition and on reset. They are stable in IDLE.
- Arithmetic: unsigned, modulo 2^WIDTH. bout is the true borrow out of the MSB.
- Counter width is $clog2(WIDTH); no wrap occurs because SHIFT exits at WIDTH−1.

Optional Feature:
- Macro SERIAL_SUB_OVF_EN.
- Defined: adds output port ovf (1 bit). ovf = signed two's-complement overflow, i.e. sign(A) != sign(B) and sign(diff) != sign(A).
  - Registered and updated together with diff; reset value 0.
  - Bin is included in the check: the test is on the final result.
- Undefined: no ovf port, no related logic; behaviour otherwise identical.

Decomposition:
- Shared package serial_subtractor_pkg holds:
  - state enum typedef (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - the default width constant.
- One natural sub-module: sub_bit_cell.
  - Pure combinational one-bit full subtractor: d = a^b^c, bo = (~a&b) | (~a&c) | (b&c).
  - Instantiated once inside the datapath.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, bin=0, pulse start → busy for 8 cycles; done at cycle 9; diff=0x02, bout=0.
- a=0x03, b=0x05, bin=0 → diff=0xFE, bout=1. Then a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1. Then a=0xFF, b=0xFF, bin=1 → diff=0xFF, bout=1.
- Start held high through the whole operation, with a_in changed mid-SHIFT → result uses the originally captured operands. A second start asserted in the DONE cycle is accepted; its done arrives exactly 9 cycles later.
- rst_n driven low at SHIFT cycle 4 → next edge: state IDLE, busy=0, done=0, diff=0, bout=0. No done pulse is issued for the aborted operation.
- With SERIAL_SUB_OVF_EN: a=0x80, b=0x01, bin=0 → diff=0x7F, bout=0, ovf=1. a=0x7F, b=0xFF → diff=0x80, bout=1, ovf=1. a=0x10, b=0x01 → diff=0x0F, ovf=0.
